// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions: opcode encodings, default address width and the
// next-PC source selector used by the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int ADDR_W_DEFAULT = 8;

  localparam logic [4:0] OP_JMP  = 5'b01110;
  localparam logic [4:0] OP_BEQ  = 5'b01111;
  localparam logic [4:0] OP_BNE  = 5'b10000;
  localparam logic [4:0] OP_CALL = 5'b10001;
  localparam logic [4:0] OP_RET  = 5'b10010;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_TARGET = 2'd1,
    PC_RETURN = 2'd2,
    PC_HOLD   = 2'd3
  } pcSel_e;

  // A conditional branch is taken only for BEQ on zero or BNE on non-zero;
  // a branch strobe with any other opcode falls through.
  function automatic logic branchTaken(input logic [4:0] opcode, input logic zeroFlag);
    return ((opcode == OP_BEQ) && zeroFlag) || ((opcode == OP_BNE) && !zeroFlag);
  endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Parameterised LIFO holding return addresses for CALL/RET.
// The caller never asserts push and pop together.
module return_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          data,
  output logic [DATA_W-1:0]          top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  wrIdx;
  logic [IDX_W-1:0]  rdIdx;

  assign wrIdx = IDX_W'(count);
  assign rdIdx = IDX_W'(count - CNT_W'(1));
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign top   = mem[rdIdx];
  assign depth = count;

  // Entry count: the only state that reset needs to clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Storage array; entries above the count are stale and never read.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[wrIdx] <= data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch address from the decoded
// control strobes and keeps a hardware return-address stack for CALL/RET.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_PC    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [4:0]                       opcode,
  input  logic                             branch,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             zeroFlag,
  input  logic [ADDR_W-1:0]                target,
  output logic [ADDR_W-1:0]                pc,
  output logic                             redirect,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stackDepth,
  output logic                             stackOverflow,
  output logic                             stackUnderflow
);

  logic [ADDR_W-1:0] pcPlus1;
  logic [ADDR_W-1:0] stackTop;
  logic [ADDR_W-1:0] nextPc;
  logic              stackFull;
  logic              stackEmpty;
  logic              doPush;
  logic              doPop;
  logic              setOverflow;
  logic              setUnderflow;
  logic              nextRedirect;
  pcSel_e            pcSel;

  assign pcPlus1 = pc + ADDR_W'(1);

  return_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (doPush),
    .pop   (doPop),
    .data  (pcPlus1),
    .top   (stackTop),
    .depth (stackDepth),
    .full  (stackFull),
    .empty (stackEmpty)
  );

  // Strobe priority ret > call > jump > branch > sequential; stall and reset freeze everything.
  always_comb begin
    pcSel        = PC_SEQ;
    nextRedirect = 1'b0;
    doPush       = 1'b0;
    doPop        = 1'b0;
    setOverflow  = 1'b0;
    setUnderflow = 1'b0;
    if (rst) begin
      pcSel = PC_SEQ;
    end else if (stall) begin
      pcSel        = PC_HOLD;
      nextRedirect = redirect;
    end else if (ret) begin
      if (stackEmpty) begin
        setUnderflow = 1'b1;
      end else begin
        doPop        = 1'b1;
        pcSel        = PC_RETURN;
        nextRedirect = 1'b1;
      end
    end else if (call) begin
      if (stackFull) begin
        setOverflow = 1'b1;
      end else begin
        doPush       = 1'b1;
        pcSel        = PC_TARGET;
        nextRedirect = 1'b1;
      end
    end else if (jump) begin
      pcSel        = PC_TARGET;
      nextRedirect = 1'b1;
    end else if (branch && branchTaken(opcode, zeroFlag)) begin
      pcSel        = PC_TARGET;
      nextRedirect = 1'b1;
    end
  end

  // Next-PC multiplexer driven by the selected source.
  always_comb begin
    nextPc = pcPlus1;
    case (pcSel)
      PC_TARGET: nextPc = target;
      PC_RETURN: nextPc = stackTop;
      PC_HOLD:   nextPc = pc;
      default:   nextPc = pcPlus1;
    endcase
  end

  // Architectural PC, redirect marker and sticky stack error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= ADDR_W'(RESET_PC);
      redirect       <= 1'b0;
      stackOverflow  <= 1'b0;
      stackUnderflow <= 1'b0;
    end else begin
      pc             <= nextPc;
      redirect       <= nextRedirect;
      stackOverflow  <= stackOverflow | setOverflow;
      stackUnderflow <= stackUnderflow | setUnderflow;
    end
  end

endmodule
